// File: rtl/md_unit_pkg.sv
// Shared md_op encoding, FSM state type and the HI/LO result helper for the
// E-stage multiply/divide unit.
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_BDS   = 4'd9;

  typedef enum logic {ST_IDLE, ST_RUN} md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // Returns the new {HI,LO}; a zero divisor leaves the current values intact.
  function automatic hilo_t md_result(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input hilo_t cur);
    hilo_t r;
    logic signed [63:0] sp;
    logic [63:0] up;
    r  = cur;
    sp = '0;
    up = '0;
    case (op)
      MD_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {r.hi, r.lo} = sp;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {r.hi, r.lo} = up;
      end
      MD_DIV: begin
        // INT_MIN / -1 overflows a 32-bit quotient; pin it to the wrapped value.
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = a;
            r.hi = 32'd0;
          end else begin
            r.lo = $signed(a) / $signed(b);
            r.hi = $signed(a) % $signed(b);
          end
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage control <-> multiply/divide unit bus. md_op is sampled every cycle;
// start is a same-cycle acceptance strobe, busy is registered.
interface md_unit_if;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output md_op, rs_data, rt_data,
                  input  start, busy, md_out, hi, lo);
  modport slave  (input  md_op, rs_data, rt_data,
                  output start, busy, md_out, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO; results are computed from
// the latched operands on the final busy cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus,
  output md_state_e dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0]  op_q, op_n;
  logic [31:0] a_q, a_n, b_q, b_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic        start_c;
  hilo_t       res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    start_c = 1'b0;
    res     = md_result(op_q, a_q, b_q, '{hi: hi_q, lo: lo_q});
    case (state_q)
      ST_IDLE: begin
        if (is_start_op(bus.md_op)) begin
          start_c = 1'b1;
          state_n = ST_RUN;
          op_n    = bus.md_op;
          a_n     = bus.rs_data;
          b_n     = bus.rt_data;
          cnt_n   = (bus.md_op == MD_MULT || bus.md_op == MD_MULTU) ?
                    CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (bus.md_op == MD_MTHI) begin
          hi_n = bus.rs_data;
        end else if (bus.md_op == MD_MTLO) begin
          lo_n = bus.rs_data;
        end
      end
      ST_RUN: begin
        // Requests arriving while running are dropped; only the countdown advances.
        cnt_n = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_n    = res.hi;
          lo_n    = res.lo;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.md_out = 32'd0;
    if (bus.md_op == MD_MFHI)      bus.md_out = hi_q;
    else if (bus.md_op == MD_MFLO) bus.md_out = lo_q;
  end

  assign bus.start = start_c;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus a randomized op
// stream checked against a 64-bit arithmetic reference model.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  md_state_e dbg_state;
  int total = 0;
  int bad = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model of a completed start op, in plain 64-bit arithmetic.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT:  begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
      MD_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      MD_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
      end
      MD_DIVU: if (b != 0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_op = op;
    bus.rs_data = a;
    bus.rt_data = b;
  endtask

  // Launches a start op, measures busy length, checks HI/LO hold then update.
  task automatic run_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n, exp_n;
    logic [31:0] old_h, old_l;
    exp_n = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
    old_h = hi_m;
    old_l = lo_m;
    @(negedge clk);
    drive(op, a, b);
    #1;
    total++;
    if (bus.start !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL start_strobe op=%0d: start=%b busy=%b, required start=1 busy=0", op, bus.start, bus.busy);
    end
    @(posedge clk);
    #1 drive(MD_NONE, $urandom, $urandom);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
      total++;
      if (bus.hi !== old_h || bus.lo !== old_l || bus.start !== 1'b0) begin
        bad++;
        $display("FAIL hold_while_busy op=%0d: hi=%h lo=%h start=%b, required hi=%h lo=%h start=0",
                 op, bus.hi, bus.lo, bus.start, old_h, old_l);
      end
      if (n > 3 * DC) break;
    end
    total++;
    if (n != exp_n) begin
      bad++;
      $display("FAIL busy_length op=%0d: got %0d cycles, required %0d", op, n, exp_n);
    end
    model_op(op, a, b, hi_m, lo_m);
    total++;
    if (bus.hi !== hi_m || bus.lo !== lo_m) begin
      bad++;
      $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
               op, a, b, bus.hi, bus.lo, hi_m, lo_m);
    end
  endtask

  task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    drive(op, a, $urandom);
    @(posedge clk);
    #1 drive(MD_NONE, 0, 0);
    if (op == MD_MTHI) hi_m = a; else lo_m = a;
    @(negedge clk);
    total++;
    if (bus.hi !== hi_m || bus.lo !== lo_m || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL move_to op=%0d: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
               op, bus.hi, bus.lo, bus.busy, hi_m, lo_m);
    end
  endtask

  task automatic run_mf(input logic [3:0] op);
    logic [31:0] exp_v;
    exp_v = (op == MD_MFHI) ? hi_m : (op == MD_MFLO) ? lo_m : 32'd0;
    @(negedge clk);
    drive(op, $urandom, $urandom);
    #1;
    total++;
    if (bus.md_out !== exp_v || bus.start !== 1'b0) begin
      bad++;
      $display("FAIL md_out op=%0d: md_out=%h start=%b, required md_out=%h start=0",
               op, bus.md_out, bus.start, exp_v);
    end
    @(posedge clk);
    #1 drive(MD_NONE, 0, 0);
    @(negedge clk);
    total++;
    if (bus.hi !== hi_m || bus.lo !== lo_m || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL no_side_effect op=%0d: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
               op, bus.hi, bus.lo, bus.busy, hi_m, lo_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(MD_MFHI, 32'hFFFF_FFFF, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 0 || bus.md_out !== 0) begin
      bad++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b md_out=%h, required all 0",
               bus.hi, bus.lo, bus.busy, bus.md_out);
    end
    reset = 1'b0;
    drive(MD_NONE, 0, 0);
    hi_m = 0;
    lo_m = 0;
  endtask

  task automatic test_mult_div();
    run_start(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    total++;
    if (hi_m !== 32'hFFFF_FFFF || lo_m !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_vector: model hi=%h lo=%h, required FFFFFFFF FFFFFFFA", hi_m, lo_m);
    end
    run_start(MD_DIVU, 32'd100, 32'd7);
    run_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_start(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_start(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    run_start(MD_MULTU, 32'h8000_0001, 32'h0000_0003);
  endtask

  task automatic test_move();
    run_mt(MD_MTHI, 32'h1234_5678);
    run_mf(MD_MFHI);
    run_mt(MD_MTLO, 32'h9ABC_DEF0);
    run_mf(MD_MFLO);
    run_mf(MD_BDS);
  endtask

  task automatic test_div_zero();
    run_mt(MD_MTHI, 32'd5);
    run_mt(MD_MTLO, 32'd6);
    run_start(MD_DIV, 32'd9, 32'd0);
    run_start(MD_DIVU, 32'd9, 32'd0);
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [31:0] old_h;
    old_h = hi_m;
    @(negedge clk);
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 drive(MD_NONE, 0, 0);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
      if (n == 2) drive(MD_MTLO, 32'd1, 0);
      else if (n == 3) drive(MD_DIV, 32'd9, 32'd2);
      else if (n == 4) drive(MD_MFHI, 0, 0);
      else drive(MD_NONE, 0, 0);
      #1;
      if (n == 4) begin
        total++;
        if (bus.md_out !== old_h) begin
          bad++;
          $display("FAIL mfhi_while_busy: md_out=%h, required %h", bus.md_out, old_h);
        end
      end
      total++;
      if (bus.start !== 1'b0) begin
        bad++;
        $display("FAIL start_while_busy cycle %0d: start=1, required 0", n);
      end
      if (n > 3 * DC) break;
    end
    drive(MD_NONE, 0, 0);
    total++;
    if (n != MC || bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      bad++;
      $display("FAIL busy_ignore: cycles=%0d hi=%h lo=%h, required %0d FFFFFFFE 00000001",
               n, bus.hi, bus.lo, MC);
    end
    hi_m = 32'hFFFF_FFFE;
    lo_m = 32'h0000_0001;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m) begin
      bad++;
      $display("FAIL no_restart: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
               bus.busy, bus.hi, bus.lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    run_mt(MD_MTHI, 32'hAAAA_5555);
    @(negedge clk);
    drive(MD_DIV, 32'd100, 32'd3);
    @(posedge clk);
    #1 drive(MD_NONE, 0, 0);
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = 0;
    lo_m = 0;
    total++;
    if (n != 4 || bus.busy !== 0 || bus.hi !== 0 || bus.lo !== 0) begin
      bad++;
      $display("FAIL reset_mid: busy_seen=%0d busy=%b hi=%h lo=%h, required 4 0 0 0",
               n, bus.busy, bus.hi, bus.lo);
    end
    repeat (DC + 4) @(negedge clk);
    total++;
    if (bus.busy !== 0 || bus.hi !== 0 || bus.lo !== 0) begin
      bad++;
      $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h, required 0 0 0",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      if (is_start_op(op)) run_start(op, a, b);
      else if (op == MD_MTHI || op == MD_MTLO) run_mt(op, a);
      else run_mf(op);
    end
  endtask

  initial begin
    drive(MD_NONE, 0, 0);
    test_reset();
    test_mult_div();
    test_move();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
